// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, register-file geometry and the
// reset values of the global and stack pointers.
package cpu_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_IDX     = 0;

  localparam int          GP_IDX_DEF  = 28;
  localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;
  localparam int          SP_IDX_DEF  = 29;
  localparam logic [31:0] SP_INIT_DEF = 32'h0000_3ffc;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set when a producer issues, cleared by its
// writeback, looked up by every read port.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rpend
);

  // r0 has no pend bit; the index range starts at 1.
  logic [NUM_REGS-1:ZERO_IDX+1] pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      for (int i = ZERO_IDX + 1; i < NUM_REGS; i++) begin
        // A new producer issued on the same edge as an older writeback wins.
        if (issue_valid && issue_addr == ADDR_W'(i))
          pend[i] <= 1'b1;
        else if ((we0 && waddr0 == ADDR_W'(i)) || (we1 && waddr1 == ADDR_W'(i)))
          pend[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rpend
    logic [ADDR_W-1:0] ra;
    logic              p;
    logic              wr_hit;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      p      = 1'b0;
      wr_hit = 1'b0;
      for (int i = ZERO_IDX + 1; i < NUM_REGS; i++) begin
        if (ra == ADDR_W'(i)) begin
          p      = pend[i];
          wr_hit = (we0 && waddr0 == ADDR_W'(i)) || (we1 && waddr1 == ADDR_W'(i));
        end
      end
    end

    // A forwarded write is by definition the valid value.
    assign rpend[k] = p && !((BYPASS != 0) && wr_hit);
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, optional write-to-read
// bypass and a pending scoreboard for hazard detection.
module regfile_mp_sb
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = DATA_W_DEF,
  parameter int              NUM_REGS = NUM_REGS_DEF,
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              NUM_RD   = 2,
  parameter int              BYPASS   = 1,
  parameter int              GP_IDX   = GP_IDX_DEF,
  parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(GP_INIT_DEF),
  parameter int              SP_IDX   = SP_IDX_DEF,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend
);

  logic [DATA_W-1:0]            regs [ZERO_IDX+1:NUM_REGS-1];
  logic [NUM_REGS-1:ZERO_IDX+1] w0_sel;
  logic [NUM_REGS-1:ZERO_IDX+1] w1_sel;

  // Out-of-range and zero indices decode to no select at all.
  always_comb begin
    w0_sel = '0;
    w1_sel = '0;
    for (int i = ZERO_IDX + 1; i < NUM_REGS; i++) begin
      w0_sel[i] = we0 && (waddr0 == ADDR_W'(i));
      w1_sel[i] = we1 && (waddr1 == ADDR_W'(i));
    end
  end

  // NOTE: the register array is reset deliberately -- software relies on
  // known GP/SP and zeroed registers, so this stays a flop array, not a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = ZERO_IDX + 1; i < NUM_REGS; i++) begin
        if (i == GP_IDX)      regs[i] <= GP_INIT;
        else if (i == SP_IDX) regs[i] <= SP_INIT;
        else                  regs[i] <= '0;
      end
    end else begin
      for (int i = ZERO_IDX + 1; i < NUM_REGS; i++) begin
        // NOTE: both are non-blocking; the later one scheduled (port 1) wins.
        if (w0_sel[i]) regs[i] <= wdata0;
        if (w1_sel[i]) regs[i] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    logic              hit0;
    logic              hit1;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    // NOTE: every variable gets a default before the loop, so no latch
    // is inferred for indices that match nothing.
    always_comb begin
      val  = '0;
      hit0 = 1'b0;
      hit1 = 1'b0;
      for (int i = ZERO_IDX + 1; i < NUM_REGS; i++) begin
        if (ra == ADDR_W'(i)) begin
          val  = regs[i];
          hit0 = w0_sel[i];
          hit1 = w1_sel[i];
        end
      end
      if (BYPASS != 0) begin
        if (hit1)      val = wdata1;
        else if (hit0) val = wdata0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = val;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .we0         (we0),
    .waddr0      (waddr0),
    .we1         (we1),
    .waddr1      (waddr1),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .raddr       (raddr),
    .rpend       (rpend)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: expected reads are queued as stimulus is
// applied and compared once the combinational outputs have settled.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk;
  logic             reset;
  logic             we0, we1, issue_valid;
  logic [AW-1:0]    waddr0, waddr1, issue_addr;
  logic [DW-1:0]    wdata0, wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rpend;

  typedef struct {
    logic [8*12-1:0] tag;
    int              port;
    logic [DW-1:0]   data;
    logic            pend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  regfile_mp_sb dut (
    .clk         (clk),
    .reset       (reset),
    .we0         (we0),
    .waddr0      (waddr0),
    .wdata0      (wdata0),
    .we1         (we1),
    .waddr1      (waddr1),
    .wdata1      (wdata1),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .raddr       (raddr),
    .rdata       (rdata),
    .rpend       (rpend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_rd(input logic [8*12-1:0] tag, input int port,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic pend);
    exp_t e;
    raddr[port*AW +: AW] = addr;
    e.tag  = tag;
    e.port = port;
    e.data = data;
    e.pend = pend;
    q.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t          e;
    logic [DW-1:0] obs_d;
    logic          obs_p;
    #1;
    while (q.size() > 0) begin
      e     = q.pop_front();
      obs_d = rdata[e.port*DW +: DW];
      obs_p = rpend[e.port];
      checks++;
      assert (obs_d === e.data) passed++;
      else begin
        failed++;
        $error("FAIL %0s rdata: observed %h expected %h", e.tag, obs_d, e.data);
      end
      checks++;
      assert (obs_p === e.pend) passed++;
      else begin
        failed++;
        $error("FAIL %0s rpend: observed %b expected %b", e.tag, obs_p, e.pend);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    reset       = 1'b0;
    we0         = 1'b0;
    we1         = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we0 = 1'b0; we1 = 1'b0; issue_valid = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    issue_addr = '0; raddr = '0;
    tick();

    // Reset contents
    expect_rd("rst_gp", 0, 5'd28, 32'h0000_1800, 1'b0);
    expect_rd("rst_sp", 1, 5'd29, 32'h0000_3ffc, 1'b0);
    check_outputs();
    expect_rd("rst_r5", 0, 5'd5, 32'h0, 1'b0);
    expect_rd("rst_r0", 1, 5'd0, 32'h0, 1'b0);
    check_outputs();

    // Write then read
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hDEAD_BEEF;
    tick();
    expect_rd("wr_r7", 0, 5'd7, 32'hDEAD_BEEF, 1'b0);
    check_outputs();

    // r0 is never written nor bypassed
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1234_5678;
    expect_rd("r0_byp", 0, 5'd0, 32'h0, 1'b0);
    check_outputs();
    tick();
    expect_rd("r0_read", 0, 5'd0, 32'h0, 1'b0);
    expect_rd("r7_keep", 1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    check_outputs();

    // Dual write to the same index: port 1 wins
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h22;
    expect_rd("dual_byp", 0, 5'd3, 32'h22, 1'b0);
    expect_rd("dual_oth", 1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    check_outputs();
    tick();
    expect_rd("dual_st", 0, 5'd3, 32'h22, 1'b0);
    check_outputs();

    // Port 0 bypass alone
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hA5A5_0001;
    expect_rd("byp0", 1, 5'd10, 32'hA5A5_0001, 1'b0);
    check_outputs();
    tick();

    // Scoreboard: issue sets pend on the next edge
    issue_valid = 1'b1; issue_addr = 5'd9;
    expect_rd("iss_same", 0, 5'd9, 32'h0, 1'b0);
    check_outputs();
    tick();
    expect_rd("iss_pend", 0, 5'd9, 32'h0, 1'b1);
    expect_rd("iss_oth", 1, 5'd10, 32'hA5A5_0001, 1'b0);
    check_outputs();

    // Writeback forwards and masks pend in the same cycle, clears it after
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h5A;
    expect_rd("wb_byp", 0, 5'd9, 32'h5A, 1'b0);
    check_outputs();
    tick();
    expect_rd("wb_clr", 0, 5'd9, 32'h5A, 1'b0);
    check_outputs();

    // Issue and write on the same edge: pend ends at 1, data stored
    issue_valid = 1'b1; issue_addr = 5'd9;
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h77;
    expect_rd("iw_byp", 0, 5'd9, 32'h77, 1'b0);
    check_outputs();
    tick();
    expect_rd("iw_after", 0, 5'd9, 32'h77, 1'b1);
    check_outputs();

    // Write to one register while issuing another
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    issue_valid = 1'b1; issue_addr = 5'd11;
    tick();
    expect_rd("mix_r9", 0, 5'd9, 32'h99, 1'b0);
    expect_rd("mix_r11", 1, 5'd11, 32'h0, 1'b1);
    check_outputs();

    // Reset in the middle of a pending producer
    issue_valid = 1'b1; issue_addr = 5'd4;
    tick();
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hFF;
    tick();
    expect_rd("r4_ff", 0, 5'd4, 32'hFF, 1'b0);
    check_outputs();
    issue_valid = 1'b1; issue_addr = 5'd4;
    tick();
    expect_rd("r4_pend", 0, 5'd4, 32'hFF, 1'b1);
    check_outputs();
    reset = 1'b1;
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hAA;
    issue_valid = 1'b1; issue_addr = 5'd12;
    tick();
    expect_rd("mr_r4", 0, 5'd4, 32'h0, 1'b0);
    expect_rd("mr_gp", 1, 5'd28, 32'h0000_1800, 1'b0);
    check_outputs();
    expect_rd("mr_r12", 0, 5'd12, 32'h0, 1'b0);
    expect_rd("mr_r7", 1, 5'd7, 32'h0, 1'b0);
    check_outputs();
    expect_rd("mr_r11", 0, 5'd11, 32'h0, 1'b0);
    check_outputs();

    // Write with no matching issue after reset
    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h33;
    tick();
    expect_rd("post_wr", 0, 5'd4, 32'h33, 1'b0);
    expect_rd("post_sp", 1, 5'd29, 32'h0000_3ffc, 1'b0);
    check_outputs();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the CPU's 32x32 register file.
- Adds configurable width, depth and read-port count, plus a second write port (late/load writeback).
- Adds optional same-cycle write-to-read bypass and a per-register pending scoreboard for pipeline hazard detection.
- Sits between decode/issue (read ports, issue marks) and the writeback stages (write ports).

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of architectural registers, including hardwired r0.
- ADDR_W, 5: register index width; must satisfy 2^ADDR_W >= NUM_REGS.
- NUM_RD, 2: number of read ports.
- BYPASS, 1: 1 = same-cycle write data is forwarded to the read ports; 0 = reads see stored contents only.
- GP_IDX, 28: index of the global-pointer register.
- GP_INIT, 32'h00001800: reset value of GP_IDX.
- SP_IDX, 29: index of the stack-pointer register.
- SP_INIT, 32'h00003ffc: reset value of SP_IDX.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- we0  in  1  write enable, port 0 (main writeback).
- waddr0  in  ADDR_W  write index, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (late writeback).
- waddr1  in  ADDR_W  write index, port 1.
- wdata1  in  DATA_W  write data, port 1.
- issue_valid  in  1  marks issue_addr as having an in-flight producer.
- issue_addr  in  ADDR_W  destination register of the issued instruction.
- raddr  in  NUM_RD*ADDR_W  read indices, packed; port k occupies bits [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data, packed the same way.
- rpend  out  NUM_RD  per-read-port pending flag; 1 = the value is not yet valid.

Behaviour:
- Storage: registers 1..NUM_REGS-1 are flops; r0 is not stored.
  - Reads of index 0 return 0 with rpend=0.
  - Writes and issues to index 0 are ignored.
- Indices >= NUM_REGS: writes and issues are ignored; reads return 0 with rpend=0.
- Reads are combinational (zero latency).
  - BYPASS=0: rdata = stored value.
  - BYPASS=1: if an enabled write port targets the read index (nonzero) this cycle, rdata = that port's wdata.
  - When both write ports hit the read index, port 1 data wins.
- Writes: commit on the rising edge when weN=1 and waddrN != 0.
  - When we0 and we1 target the same index, port 1 wins (both for storage and for bypass).
- Scoreboard: one pend bit per register; r0 is never pending.
  - Edge with issue_valid=1: pend[issue_addr] <= 1.
  - Edge with a write: pend[waddrN] <= 0.
  - Issue and write to the same index on the same edge: pend ends at 1 (the new producer wins); the write data is still stored.
- rpend[k] = pend[raddr_k], except it is forced to 0 when BYPASS=1 and a write hits raddr_k this cycle.
- Reset (reset=1 at the edge): all registers <= 0, except GP_IDX <= GP_INIT and SP_IDX <= SP_INIT; all pend bits <= 0.
  - Reset takes priority over any simultaneous write or issue on that edge.
  - Outputs during reset are combinational views of current state. From the first post-reset cycle onward: rdata = reset contents (GP/SP values, 0 elsewhere), rpend = 0.
- Reset in the middle of a pending producer: pend is cleared; a subsequent write with no matching issue is accepted normally.
- No stalls and no backpressure: the block always accepts writes and issues.

Decomposition:
- Shared package (cpu_pkg): DATA_W/ADDR_W defaults, GP/SP index and init constants, and a zero-register index constant; the issue and decode stages reuse these.
- One natural sub-module: regfile_scoreboard, holding the pend bit vector with its set/clear/priority logic and the rpend lookup. Storage and bypass muxing stay in the top module.

Test Plan:
- Reset value check: assert reset for 1 cycle, read r28/r29/r5 -> 32'h00001800 / 32'h00003ffc / 0, all rpend=0.
- Write then read: we0=1, waddr0=7, wdata0=32'hDEADBEEF; next cycle raddr port0=7 -> rdata=32'hDEADBEEF.
- r0 protection: we0=1, waddr0=0, wdata0=32'h12345678; next cycle raddr=0 -> rdata=0, rpend=0.
- Dual-write conflict, BYPASS=1, same cycle: we0 (r3 <= 32'h11) and we1 (r3 <= 32'h22).
  - During that cycle, raddr=3 -> rdata=32'h22.
  - Next cycle the stored value of r3 = 32'h22.
- Scoreboard:
  - issue r9 -> next cycle rpend=1 for raddr=9.
  - we1 writes r9 <= 32'h5A: rpend=0 in that same cycle (bypass) and rdata=32'h5A.
  - Issue and write r9 on the same edge -> afterwards rpend=1 and stored r9 = the written data.
- Reset mid-operation: issue r4, write r4 <= 32'hFF, then assert reset together with we0 (r4 <= 32'hAA) -> afterwards r4=0 and rpend=0.
